// File: rtl/ysyx_220053_dmem_resp_pkg.sv
// Shared definitions for the data-side line responder.
// Holds the default widths, the FSM state encoding and a small index-width helper.
// Both the responder top and its line buffer import this package.
package ysyx_220053_dmem_resp_pkg;

  localparam int unsigned ADDR_W_DEF = 64;
  localparam int unsigned LINE_W_DEF = 128;
  localparam int unsigned BEAT_W_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Index width that stays legal (>=1) even for a single-beat line.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_220053_line_buf.sv
// Line buffer for the data-side responder.
// Holds one LINE_W line as NBEATS slots of BEAT_W bits.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load_i/line_i     parallel load of the whole line (request accept)
//   wr_i/wr_idx_i/
//   wr_data_i         single-slot write (read beat returning from memory)
//   rd_idx_i          slot select for rd_slot_c_o
//   line_o            current buffer contents (registered)
//   rd_slot_c_o       combinational slot read at rd_idx_i
module ysyx_220053_line_buf
  import ysyx_220053_dmem_resp_pkg::*;
#(
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned BEAT_W = BEAT_W_DEF,
  parameter int unsigned IDX_W  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              wr_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [BEAT_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [LINE_W-1:0] line_o,
  output logic [BEAT_W-1:0] rd_slot_c_o
);

  localparam int unsigned NBEATS = LINE_W / BEAT_W;

  logic [NBEATS-1:0][BEAT_W-1:0] slots_q, slots_d;

  // Load has priority; a slot write only lands inside the line.
  always_comb begin
    slots_d = slots_q;
    if (load_i) begin
      slots_d = line_i;
    end else if (wr_i && (32'(wr_idx_i) < NBEATS)) begin
      slots_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) slots_q <= '0;
    else     slots_q <= slots_d;
  end

  assign line_o      = slots_q;
  assign rd_slot_c_o = (32'(rd_idx_i) < NBEATS) ? slots_q[rd_idx_i] : slots_q[0];

endmodule

// File: rtl/ysyx_220053_dmem_resp.sv
// Data-side line responder: accepts one line request from the memory unit and
// services it as a burst of BEAT_W beats on the backing-memory port, then pulses
// d_rw_ready_o for one cycle. Read lines are assembled in the line buffer; write
// lines stay in it, so d_data_read_o echoes the written line.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   d_rw_addr_i/req_i/
//   valid_i/w_data_i          line request (req 1 = write), sampled only at accept
//   d_data_read_o             line buffer contents, valid with d_rw_ready_o
//   d_rw_ready_o              one-cycle completion pulse
//   mem_valid_o/we_o/
//   addr_o/wdata_o            beat request to backing memory
//   mem_ready_i/rdata_i       beat handshake and read data
module ysyx_220053_dmem_resp
  import ysyx_220053_dmem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF,
  parameter int unsigned BEAT_W = BEAT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] d_rw_addr_i,
  input  logic              d_rw_req_i,
  input  logic              d_rw_valid_i,
  input  logic [LINE_W-1:0] d_rw_w_data_i,
  output logic [LINE_W-1:0] d_data_read_o,
  output logic              d_rw_ready_o,
  output logic              mem_valid_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [BEAT_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [BEAT_W-1:0] mem_rdata_i
);

  localparam int unsigned NBEATS     = LINE_W / BEAT_W;
  localparam int unsigned IDX_W      = idx_width(NBEATS);
  localparam int unsigned OFFS_W     = $clog2(LINE_W / 8);
  localparam int unsigned BEAT_BYTES = BEAT_W / 8;
  localparam int unsigned LAST_BEAT  = NBEATS - 1;
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'((64'd1 << OFFS_W) - 64'd1);

  dmem_state_e       state_q, state_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              armed_q, armed_d;
  logic              req_q, req_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BEAT_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ready_q, ready_d;

  logic              accept;
  logic              lb_wr;
  logic              last_beat;
  logic [IDX_W-1:0]  nxt_idx;
  logic [BEAT_W-1:0] nxt_slot;

  ysyx_220053_line_buf #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (IDX_W)
  ) u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .load_i      (accept),
    .line_i      (d_rw_w_data_i),
    .wr_i        (lb_wr),
    .wr_idx_i    (beat_q),
    .wr_data_i   (mem_rdata_i),
    .rd_idx_i    (nxt_idx),
    .line_o      (d_data_read_o),
    .rd_slot_c_o (nxt_slot)
  );

  // Next-state, beat sequencing and registered output values.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    armed_d     = armed_q;
    req_d       = req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    accept      = 1'b0;
    lb_wr       = 1'b0;
    last_beat   = (beat_q == IDX_W'(LAST_BEAT));
    nxt_idx     = beat_q + IDX_W'(1);

    // A held-high valid after completion must drop before it counts again.
    if (!d_rw_valid_i) armed_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (d_rw_valid_i && armed_q) begin
          accept      = 1'b1;
          armed_d     = 1'b0;
          req_d       = d_rw_req_i;
          beat_d      = '0;
          mem_addr_d  = d_rw_addr_i & ~OFFS_MASK;
          // Buffer loads on this same edge, so beat 0 comes straight from the input.
          mem_wdata_d = d_rw_w_data_i[BEAT_W-1:0];
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        if (mem_ready_i) begin
          lb_wr = ~req_q;
          if (last_beat) begin
            state_d = ST_RESP;
          end else begin
            beat_d      = nxt_idx;
            mem_addr_d  = mem_addr_q + ADDR_W'(BEAT_BYTES);
            mem_wdata_d = nxt_slot;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_valid_d = (state_d == ST_XFER);
    mem_we_d    = (state_d == ST_XFER) & req_d;
    ready_d     = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      armed_q     <= 1'b1;
      req_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      armed_q     <= armed_d;
      req_q       <= req_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ready_q     <= ready_d;
    end
  end

  assign d_rw_ready_o = ready_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_ysyx_220053_dmem_resp.sv
module tb_ysyx_220053_dmem_resp;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  d_rw_addr_i;
  logic         d_rw_req_i;
  logic         d_rw_valid_i;
  logic [127:0] d_rw_w_data_i;
  logic [127:0] d_data_read_o;
  logic         d_rw_ready_o;
  logic         mem_valid_o;
  logic         mem_we_o;
  logic [63:0]  mem_addr_o;
  logic [63:0]  mem_wdata_o;
  logic         mem_ready_i;
  logic [63:0]  mem_rdata_i;

  ysyx_220053_dmem_resp dut (
    .clk           (clk),
    .rst           (rst),
    .d_rw_addr_i   (d_rw_addr_i),
    .d_rw_req_i    (d_rw_req_i),
    .d_rw_valid_i  (d_rw_valid_i),
    .d_rw_w_data_i (d_rw_w_data_i),
    .d_data_read_o (d_data_read_o),
    .d_rw_ready_o  (d_rw_ready_o),
    .mem_valid_o   (mem_valid_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_ready_i   (mem_ready_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  addr;
    logic         req;
    logic [127:0] wline;
    logic [63:0]  rd0;
    logic [63:0]  rd1;
    logic [63:0]  a0;
    logic [63:0]  a1;
    logic [127:0] line;
    int           stall;  // cycles mem_ready_i held low on beat 0
    bit           drop;   // drop valid and scramble inputs right after accept
    int           hold;   // cycles valid stays high after ready
    bit           abort;  // assert rst while beat 1 is outstanding
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
  } beat_t;

  beat_t        beat_q[$];
  logic [127:0] resp_q[$];
  logic [63:0]  rd_q[$];

  int n_vec = 0;
  int n_err = 0;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] addr, input logic req, input logic [127:0] wl,
                              input logic [63:0] r0, input logic [63:0] r1,
                              input logic [63:0] a0, input logic [63:0] a1,
                              input logic [127:0] line, input int stall, input bit drop,
                              input int hold, input bit abort);
    vec_t v;
    v.addr = addr; v.req = req; v.wline = wl; v.rd0 = r0; v.rd1 = r1;
    v.a0 = a0; v.a1 = a1; v.line = line; v.stall = stall; v.drop = drop;
    v.hold = hold; v.abort = abort;
    return v;
  endfunction

  task automatic run_txn(input vec_t v);
    int    cyc = 0;
    int    stall_left = v.stall;
    int    beat = 0;
    int    quiet;
    bit    done = 1'b0;
    beat_t b;
    @(negedge clk);
    mem_ready_i   = 1'b0;
    d_rw_addr_i   = v.addr;
    d_rw_req_i    = v.req;
    d_rw_w_data_i = v.wline;
    d_rw_valid_i  = 1'b1;
    b.addr = v.a0; b.we = v.req; b.wdata = v.wline[63:0];   beat_q.push_back(b);
    b.addr = v.a1; b.we = v.req; b.wdata = v.wline[127:64]; beat_q.push_back(b);
    rd_q.push_back(v.rd0);
    rd_q.push_back(v.rd1);
    resp_q.push_back(v.line);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (v.drop && cyc == 1) begin
        d_rw_valid_i  = 1'b0;
        d_rw_addr_i   = 64'h1234_5670;
        d_rw_req_i    = ~v.req;
        d_rw_w_data_i = '1;
      end
      if (d_rw_ready_o) begin
        chk("resp_data", d_data_read_o, resp_q.pop_front());
        chk("latency", 128'(cyc), 128'(3 + v.stall));
        chk("beats_left", 128'(beat_q.size()), 128'd0);
        chk("resp_mem_idle", {127'd0, mem_valid_o}, 128'd0);
        mem_ready_i  = 1'b0;
        d_rw_valid_i = (v.hold > 0);
        quiet = (v.hold > 0) ? v.hold : 1;
        for (int i = 0; i < quiet; i++) begin
          @(negedge clk);
          chk("post_resp_quiet", {126'd0, mem_valid_o, d_rw_ready_o}, 128'd0);
        end
        d_rw_valid_i = 1'b0;
        done = 1'b1;
      end else if (mem_valid_o) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {127'd0, mem_valid_o}, 128'd0);
          done = 1'b1;
        end else begin
          b = beat_q[0];
          chk("beat_addr", {64'd0, mem_addr_o}, {64'd0, b.addr});
          chk("beat_we", {127'd0, mem_we_o}, {127'd0, b.we});
          if (b.we) chk("beat_wdata", {64'd0, mem_wdata_o}, {64'd0, b.wdata});
          if (v.abort && beat == 1) begin
            rst          = 1'b1;
            d_rw_valid_i = 1'b0;
            mem_ready_i  = 1'b0;
            @(negedge clk);
            chk("abort_valid", {127'd0, mem_valid_o}, 128'd0);
            chk("abort_ready", {127'd0, d_rw_ready_o}, 128'd0);
            chk("abort_data", d_data_read_o, 128'd0);
            rst = 1'b0;
            beat_q.delete();
            resp_q.delete();
            rd_q.delete();
            done = 1'b1;
          end else if (stall_left > 0) begin
            stall_left--;
            mem_ready_i = 1'b0;
          end else begin
            void'(beat_q.pop_front());
            mem_ready_i = 1'b1;
            mem_rdata_i = rd_q.pop_front();
            beat++;
          end
        end
      end else begin
        mem_ready_i = 1'b0;
      end
    end
    if (!done) begin
      chk("timeout", 128'(cyc), 128'd0);
      beat_q.delete();
      resp_q.delete();
      rd_q.delete();
      d_rw_valid_i = 1'b0;
      mem_ready_i  = 1'b0;
    end
    rd_q.delete();
  endtask

  initial begin
    vecs[0] = mk(64'h8000_0018, 1'b0, '0, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                 64'h8000_0010, 64'h8000_0018,
                 128'h2222_2222_2222_2222_1111_1111_1111_1111, 0, 1'b0, 0, 1'b0);
    vecs[1] = mk(64'h8000_1000, 1'b1, 128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB, 64'h0, 64'h0,
                 64'h8000_1000, 64'h8000_1008,
                 128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB, 0, 1'b0, 0, 1'b0);
    vecs[2] = mk(64'h8000_2000, 1'b0, '0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                 64'h8000_2000, 64'h8000_2008,
                 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 5, 1'b0, 0, 1'b0);
    vecs[3] = mk(64'h0000_0000_0000_003F, 1'b1, 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF,
                 64'h0, 64'h0, 64'h30, 64'h38,
                 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF, 5, 1'b0, 0, 1'b0);
    vecs[4] = mk(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, '0, 64'h0A0A_0A0A_0A0A_0A0A, 64'h0B0B_0B0B_0B0B_0B0B,
                 64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8,
                 128'h0B0B_0B0B_0B0B_0B0B_0A0A_0A0A_0A0A_0A0A, 0, 1'b0, 3, 1'b0);
    vecs[5] = mk(64'h1000_0040, 1'b0, '0, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                 64'h1000_0040, 64'h1000_0048,
                 128'h6666_6666_6666_6666_5555_5555_5555_5555, 0, 1'b0, 0, 1'b0);
    vecs[6] = mk(64'h8000_3000, 1'b0, '0, 64'hDEAD_DEAD_DEAD_DEAD, 64'hBEEF_BEEF_BEEF_BEEF,
                 64'h8000_3000, 64'h8000_3008, '0, 0, 1'b0, 0, 1'b1);
    vecs[7] = mk(64'h8000_3008, 1'b0, '0, 64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888,
                 64'h8000_3000, 64'h8000_3008,
                 128'h8888_8888_8888_8888_7777_7777_7777_7777, 0, 1'b0, 0, 1'b0);
    vecs[8] = mk(64'h8000_4008, 1'b0, '0, 64'h9999_9999_9999_9999, 64'hAAAA_0000_AAAA_0000,
                 64'h8000_4000, 64'h8000_4008,
                 128'hAAAA_0000_AAAA_0000_9999_9999_9999_9999, 0, 1'b1, 0, 1'b0);
    vecs[9] = mk(64'h8000_5010, 1'b1, 128'h0102_0304_0506_0708_1112_1314_1516_1718, 64'h0, 64'h0,
                 64'h8000_5010, 64'h8000_5018,
                 128'h0102_0304_0506_0708_1112_1314_1516_1718, 2, 1'b1, 0, 1'b0);

    rst           = 1'b1;
    d_rw_addr_i   = '0;
    d_rw_req_i    = 1'b0;
    d_rw_valid_i  = 1'b0;
    d_rw_w_data_i = '0;
    mem_ready_i   = 1'b0;
    mem_rdata_i   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_valid", {127'd0, mem_valid_o}, 128'd0);
    chk("rst_ready", {127'd0, d_rw_ready_o}, 128'd0);
    chk("rst_we", {127'd0, mem_we_o}, 128'd0);
    chk("rst_addr", {64'd0, mem_addr_o}, 128'd0);
    chk("rst_wdata", {64'd0, mem_wdata_o}, 128'd0);
    chk("rst_data", d_data_read_o, 128'd0);

    for (int i = 0; i < NV; i++) run_txn(vecs[i]);

    repeat (2) @(negedge clk);
    chk("end_idle", {126'd0, mem_valid_o, d_rw_ready_o}, 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
